count_ctrl: RTL and testbench

COUNT_CTRL -- requirements
Module: count_ctrl

---
 rtl/count_ctrl_if.sv | 25 ++
 rtl/count_ctrl.sv | 136 +++++++++++++
 tb/tb_count_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_ctrl_if.sv
// Bundles the push-buttons, switches, preload bus and status outputs of count_ctrl.
// The master side (board / testbench) drives the controls; the slave side is the counter.
interface count_ctrl_if;
    logic       btn_start;
    logic       btn_pause;
    logic       btn_clear;
    logic       up_dn;
    logic       mode_wrap;
    logic       ld_en;
    logic [3:0] ld_val;
    logic [3:0] cnt;
    logic [1:0] state;
    logic       tick;
    logic       done;

    modport master (
        output btn_start, btn_pause, btn_clear, up_dn, mode_wrap, ld_en, ld_val,
        input  cnt, state, tick, done
    );

    modport slave (
        input  btn_start, btn_pause, btn_clear, up_dn, mode_wrap, ld_en, ld_val,
        output cnt, state, tick, done
    );
endinterface

// File: rtl/count_ctrl.sv
// 4-bit up/down counter with start/pause/clear push-buttons and a clock divider.
// The counter steps once every DIV clocks while running; it either wraps at
// 15/0 or stops there and reports done. Buttons are synchronized and edge-detected.
module count_ctrl #(
    parameter int DIV = 50000000
) (
    input logic         clk,
    input logic         rst,
    count_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [26:0] DIV_LAST = 27'(DIV - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [26:0] div_q, div_d;
    logic        done_q;

    // bit 0: first sync stage, bit 1: second sync stage, bit 2: previous value
    logic [2:0]  start_sync, pause_sync, clear_sync;

    logic start_raw, pause_raw, clear_raw;
    logic start_p, pause_p, clear_p;
    logic tick_int, at_term;

    // Two-flop synchronizers plus a history flop for each button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_sync <= 3'b000;
            pause_sync <= 3'b000;
            clear_sync <= 3'b000;
        end else begin
            start_sync <= {start_sync[1:0], bus.btn_start};
            pause_sync <= {pause_sync[1:0], bus.btn_pause};
            clear_sync <= {clear_sync[1:0], bus.btn_clear};
        end
    end

    assign start_raw = start_sync[1] & ~start_sync[2];
    assign pause_raw = pause_sync[1] & ~pause_sync[2];
    assign clear_raw = clear_sync[1] & ~clear_sync[2];

    // Clear beats pause beats start; the losers are dropped for that cycle
    assign clear_p = clear_raw;
    assign pause_p = pause_raw & ~clear_raw;
    assign start_p = start_raw & ~clear_raw & ~pause_raw;

    // Tick is gated by RUN so a divider frozen at its last value in PAUSE stays quiet
    assign tick_int = (state_q == RUN) && (div_q == DIV_LAST);
    assign at_term  = bus.up_dn ? (cnt_q == 4'hF) : (cnt_q == 4'h0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, next-count and next-divider decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        if (clear_p) begin
            state_d = IDLE;
            cnt_d   = 4'h0;
            div_d   = 27'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    div_d = 27'd0;
                    if (bus.ld_en) begin
                        cnt_d = bus.ld_val;
                    end
                    if (start_p) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    div_d = (div_q == DIV_LAST) ? 27'd0 : div_q + 27'd1;
                    if (tick_int) begin
                        if (!at_term) begin
                            cnt_d = bus.up_dn ? cnt_q + 4'd1 : cnt_q - 4'd1;
                        end else if (bus.mode_wrap) begin
                            cnt_d = bus.up_dn ? 4'h0 : 4'hF;
                        end else begin
                            state_d = DONE;
                        end
                    end
                    if (pause_p && state_d == RUN) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start_p) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    div_d = 27'd0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Count, divider and done flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 4'h0;
            div_q  <= 27'd0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            done_q <= (state_d == DONE);
        end
    end

    assign bus.cnt   = cnt_q;
    assign bus.state = state_q;
    assign bus.tick  = tick_int;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl with DIV=4: directed vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_count_ctrl;

    localparam int DIV = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    count_ctrl_if bus_if ();

    count_ctrl #(.DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integers for state, count and position within a tick period
    int         mState;
    int         mCnt;
    int         mDiv;
    // Button samples taken at previous edges, bit j = sample taken j+1 edges ago
    logic [2:0] agoS, agoP, agoC;

    task automatic modelReset();
        mState = M_IDLE;
        mCnt   = 0;
        mDiv   = 0;
        agoS   = 3'b000;
        agoP   = 3'b000;
        agoC   = 3'b000;
    endtask

    task automatic modelEdge();
        logic ps, pp, pc, wasTick;
        int   target;
        if (!rst) begin
            modelReset();
        end else begin
            // A button first seen high two edges ago after being low before acts now
            pc = agoC[1] & ~agoC[2];
            pp = agoP[1] & ~agoP[2] & ~pc;
            ps = agoS[1] & ~agoS[2] & ~pc & ~pp;
            agoS = {agoS[1:0], bus_if.btn_start};
            agoP = {agoP[1:0], bus_if.btn_pause};
            agoC = {agoC[1:0], bus_if.btn_clear};
            wasTick = (mState == M_RUN) && (mDiv == DIV - 1);
            if (pc) begin
                mState = M_IDLE;
                mCnt   = 0;
                mDiv   = 0;
            end else if (mState == M_IDLE) begin
                mDiv = 0;
                if (bus_if.ld_en) mCnt = int'(bus_if.ld_val);
                if (ps) mState = M_RUN;
            end else if (mState == M_RUN) begin
                if (wasTick) begin
                    target = bus_if.up_dn ? mCnt + 1 : mCnt - 1;
                    if (target >= 0 && target <= 15) mCnt = target;
                    else if (bus_if.mode_wrap) mCnt = (target + 16) % 16;
                    else mState = M_DONE;
                end
                mDiv = (mDiv + 1) % DIV;
                if (pp && mState == M_RUN) mState = M_PAUSE;
            end else if (mState == M_PAUSE) begin
                if (ps) mState = M_RUN;
            end else begin
                mDiv = 0;
            end
        end
    endtask

    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            modelEdge();
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic pause, input logic clear,
                                 input logic up, input logic wrap, input logic ld,
                                 input logic [3:0] ldv);
        bus_if.btn_start = start;
        bus_if.btn_pause = pause;
        bus_if.btn_clear = clear;
        bus_if.up_dn     = up;
        bus_if.mode_wrap = wrap;
        bus_if.ld_en     = ld;
        bus_if.ld_val    = ldv;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] ecnt, input logic [1:0] est,
                               input logic etick, input logic edone);
        total++;
        if (bus_if.cnt !== ecnt || bus_if.state !== est ||
            bus_if.tick !== etick || bus_if.done !== edone) begin
            bad++;
            $display("[TB] FAIL %s: got cnt=%0d state=%0d tick=%0d done=%0d, expected cnt=%0d state=%0d tick=%0d done=%0d",
                     name, bus_if.cnt, bus_if.state, bus_if.tick, bus_if.done,
                     ecnt, est, etick, edone);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, 4'(mCnt), 2'(mState),
                    (mState == M_RUN) && (mDiv == DIV - 1), mState == M_DONE);
    endtask

    task automatic doReset();
        rst = 1'b0;
        modelReset();
        runCycles(2);
        rst = 1'b1;
    endtask

    typedef struct {
        logic       start;
        logic       pause;
        logic       clear;
        logic       up;
        logic       wrap;
        logic       ld;
        logic [3:0] ldv;
        int         cycles;
        logic [3:0] ecnt;
        logic [1:0] est;
        logic       etick;
        logic       edone;
    } vec_t;

    vec_t vecs[21];

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(0, 0, 0, 1, 1, 0, 4'd0);

        //           start pause clear up wrap ld ldv  cyc cnt st tick done
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 2,  4'd13, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 3,  4'd13, 2'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4,  4'd14, 2'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  3,  4'd14, 2'd1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1,  4'd15, 2'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4,  4'd15, 2'd3, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  5,  4'd15, 2'd3, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  3,  4'd0,  2'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  2,  4'd0,  2'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  3,  4'd0,  2'd1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4,  4'd15, 2'd1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1,  4'd15, 2'd1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  2,  4'd15, 2'd1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1,  4'd14, 2'd2, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  10, 4'd14, 2'd2, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7,  3,  4'd14, 2'd2, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  3,  4'd14, 2'd1, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  7,  4'd13, 2'd1, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1,  4'd12, 2'd1, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  3,  4'd0,  2'd0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  2,  4'd0,  2'd0, 1'b0, 1'b0};

        // Reset state, sampled while reset is still asserted
        #3;
        rst = 1'b0;
        modelReset();
        runCycles(2);
        checkOutput("reset_state", 4'd0, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;

        // Basic wrapping up-count: one step every DIV clocks, 15 wraps to 0
        $display("[TB] basic up count");
        applyStimulus(1, 0, 0, 1, 1, 0, 4'd0);
        runCycles(3);
        checkOutput("basic_enter_run", 4'd0, 2'd1, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 1, 1, 0, 4'd0);
        for (int i = 1; i <= 16; i++) begin
            runCycles(DIV - 1);
            checkOutput($sformatf("basic_tick%0d", i), 4'((i - 1) % 16), 2'd1, 1'b1, 1'b0);
            runCycles(1);
            checkOutput($sformatf("basic_cnt%0d", i), 4'(i % 16), 2'd1, 1'b0, 1'b0);
        end

        // Directed vector table
        $display("[TB] vector table");
        doReset();
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].start, vecs[i].pause, vecs[i].clear, vecs[i].up,
                          vecs[i].wrap, vecs[i].ld, vecs[i].ldv);
            runCycles(vecs[i].cycles);
            checkOutput($sformatf("vec%0d", i), vecs[i].ecnt, vecs[i].est,
                        vecs[i].etick, vecs[i].edone);
        end

        // Down count with a pause landing mid-period, then resume and stop at 0
        $display("[TB] down count with pause");
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 1, 4'd2);
        runCycles(2);
        checkOutput("dp_load", 4'd2, 2'd0, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 0, 0, 1, 4'd2);
        runCycles(3);
        checkOutput("dp_run", 4'd2, 2'd1, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'd0);
        runCycles(2);
        applyStimulus(0, 1, 0, 0, 0, 0, 4'd0);
        runCycles(3);
        checkOutput("dp_paused", 4'd1, 2'd2, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'd0);
        runCycles(20);
        checkOutput("dp_frozen", 4'd1, 2'd2, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 0, 0, 0, 4'd0);
        runCycles(3);
        checkOutput("dp_resume", 4'd1, 2'd1, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'd0);
        runCycles(2);
        checkOutput("dp_remaining_tick", 4'd1, 2'd1, 1'b1, 1'b0);
        runCycles(1);
        checkOutput("dp_zero", 4'd0, 2'd1, 1'b0, 1'b0);
        runCycles(DIV);
        checkOutput("dp_done", 4'd0, 2'd3, 1'b0, 1'b1);

        // Asynchronous reset between edges while a tick is showing
        $display("[TB] async reset mid-run");
        doReset();
        applyStimulus(1, 0, 0, 1, 1, 0, 4'd0);
        runCycles(3);
        applyStimulus(0, 0, 0, 1, 1, 0, 4'd0);
        runCycles(7);
        checkOutput("ar_before", 4'd1, 2'd1, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("ar_immediate", 4'd0, 2'd0, 1'b0, 1'b0);
        runCycles(1);
        checkOutput("ar_held", 4'd0, 2'd0, 1'b0, 1'b0);

        // Button already held when reset releases gives exactly one start
        $display("[TB] button held through reset");
        applyStimulus(1, 0, 0, 1, 1, 0, 4'd0);
        runCycles(1);
        rst = 1'b1;
        runCycles(2);
        checkOutput("hr_not_yet", 4'd0, 2'd0, 1'b0, 1'b0);
        runCycles(1);
        checkOutput("hr_started", 4'd0, 2'd1, 1'b0, 1'b0);

        // Randomized run against the reference model
        $display("[TB] random run");
        applyStimulus(0, 0, 0, 1, 1, 0, 4'd0);
        doReset();
        for (int i = 0; i < 800; i++) begin
            bus_if.btn_start = ($urandom_range(0, 3) == 0);
            bus_if.btn_pause = ($urandom_range(0, 11) == 0);
            bus_if.btn_clear = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) bus_if.up_dn = ~bus_if.up_dn;
            if ($urandom_range(0, 49) == 0) bus_if.mode_wrap = ~bus_if.mode_wrap;
            bus_if.ld_en  = ($urandom_range(0, 2) == 0);
            bus_if.ld_val = 4'($urandom_range(0, 15));
            runCycles(1);
            checkModel($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
